instruction_fetcher: RTL and testbench

Per-core instruction fetch unit that produces the 32-bit instruction word consumed by the core's instruction decoder. When the core's SIMD state machine enters the fetch phase, the fetcher issues a single read request for the current PC to program memory over a valid/ready handshake, then captures and holds the returned word. It signals completion to the core scheduler and raises a sticky fault on an out-of-range PC.

---
 rtl/instruction_fetcher.sv | 115 +++++++++++
 tb/tb_instruction_fetcher.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - per-core instruction fetch unit with single-request memory handshake
//
// Purpose: when the core's SIMD state machine enters the fetch phase, issue one
// read request for current_pc to program memory, capture the returned word and
// hold it for the decoder. An out-of-range PC lands in a sticky fault state.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   enable             block enable; all state holds while low
//   simd_state         core SIMD state (SIMD_FETCH starts a fetch, SIMD_DECODE releases it)
//   current_pc         PC to fetch, sampled only when leaving IDLE
//   mem_read_valid     read request to program memory (registered)
//   mem_read_address   read address, stable while mem_read_valid is high
//   mem_read_ready     memory response strobe, data valid in the same cycle
//   mem_read_data      returned instruction word
//   instruction        captured instruction for the decoder
//   fetch_state        IDLE=0, FETCHING=1, FETCHED=2, FAULT=3
//   fetch_done         high while in FETCHED
//   fetch_fault        high while in FAULT

// Core SIMD state encodings, normally provided by common_defs.v.
`ifndef SIMD_FETCH
`define SIMD_FETCH 3'd1
`endif
`ifndef SIMD_DECODE
`define SIMD_DECODE 3'd2
`endif

module instruction_fetcher #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int PC_WIDTH          = 8,
    parameter int PROG_DEPTH        = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [2:0]                   simd_state,
    input  logic [PC_WIDTH-1:0]          current_pc,
    output logic                         mem_read_valid,
    output logic [PC_WIDTH-1:0]          mem_read_address,
    input  logic                         mem_read_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_read_data,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [1:0]                   fetch_state,
    output logic                         fetch_done,
    output logic                         fetch_fault
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCHING = 2'd1,
        FETCHED  = 2'd2,
        FAULT    = 2'd3
    } state_t;

    // The compare is one bit wider than the PC so PROG_DEPTH == 2^PC_WIDTH
    // is representable and then no PC can fault.
    localparam logic [PC_WIDTH:0] DEPTH_EXT = (PC_WIDTH+1)'(PROG_DEPTH);

    state_t state;
    logic   pc_illegal;

    assign pc_illegal  = ({1'b0, current_pc} >= DEPTH_EXT);
    assign fetch_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
            fetch_done       <= 1'b0;
            fetch_fault      <= 1'b0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (simd_state == `SIMD_FETCH) begin
                        if (pc_illegal) begin
                            state       <= FAULT;
                            fetch_fault <= 1'b1;
                        end else begin
                            mem_read_address <= current_pc;
                            mem_read_valid   <= 1'b1;
                            state            <= FETCHING;
                        end
                    end
                end
                FETCHING: begin
                    // Address and valid stay put until the response strobe.
                    if (mem_read_ready) begin
                        instruction    <= mem_read_data;
                        mem_read_valid <= 1'b0;
                        fetch_done     <= 1'b1;
                        state          <= FETCHED;
                    end
                end
                FETCHED: begin
                    // instruction is left untouched so the decoder sees a
                    // stable word for the whole decode phase.
                    if (simd_state == `SIMD_DECODE) begin
                        fetch_done <= 1'b0;
                        state      <= IDLE;
                    end
                end
                FAULT: begin
                    // Sticky until reset.
                    mem_read_valid <= 1'b0;
                    fetch_fault    <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb/tb_instruction_fetcher.sv - directed self-checking bench for instruction_fetcher

module tb_instruction_fetcher;

    localparam logic [2:0] S_OTHER  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [2:0]  simd_state;
    logic [7:0]  current_pc;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [31:0] mem_read_data;
    logic [31:0] instruction;
    logic [1:0]  fetch_state;
    logic        fetch_done;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_fetcher #(
        .INSTRUCTION_WIDTH(32),
        .PC_WIDTH(8),
        .PROG_DEPTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .simd_state(simd_state),
        .current_pc(current_pc),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .instruction(instruction),
        .fetch_state(fetch_state),
        .fetch_done(fetch_done),
        .fetch_fault(fetch_fault)
    );

    // Advance one rising edge, then settle 1ns so outputs are sampled and
    // inputs are driven away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; simd_state = S_OTHER; current_pc = 8'h00;
        mem_read_ready = 1'b0; mem_read_data = 32'h0;
        tick(); tick();
        rst = 1'b0;
        checks++; if (fetch_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", fetch_state); end
        checks++; if (mem_read_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", mem_read_valid); end
        checks++; if (mem_read_address !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", mem_read_address); end
        checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instruction); end
        checks++; if (fetch_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", fetch_done); end
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
    endtask

    task automatic test_basic_fetch();
        simd_state = S_FETCH; current_pc = 8'h05;
        tick();
        simd_state = S_OTHER;
        checks++; if (fetch_state !== 2'd1) begin failures++; $display("FAIL basic_state_fetching got=%0d exp=1", fetch_state); end
        checks++; if (mem_read_valid !== 1'b1) begin failures++; $display("FAIL basic_valid_high got=%b exp=1", mem_read_valid); end
        checks++; if (mem_read_address !== 8'h05) begin failures++; $display("FAIL basic_addr got=%h exp=05", mem_read_address); end
        checks++; if (fetch_done !== 1'b0) begin failures++; $display("FAIL basic_done_early got=%b exp=0", fetch_done); end
        mem_read_ready = 1'b1; mem_read_data = 32'h1C200000;
        tick();
        mem_read_ready = 1'b0; mem_read_data = 32'h0;
        checks++; if (instruction !== 32'h1C200000) begin failures++; $display("FAIL basic_instr got=%h exp=1c200000", instruction); end
        checks++; if (fetch_done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", fetch_done); end
        checks++; if (mem_read_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", mem_read_valid); end
        checks++; if (fetch_state !== 2'd2) begin failures++; $display("FAIL basic_state_fetched got=%0d exp=2", fetch_state); end
        tick();
        checks++; if (fetch_state !== 2'd2) begin failures++; $display("FAIL basic_hold_fetched got=%0d exp=2", fetch_state); end
        simd_state = S_DECODE;
        tick();
        simd_state = S_OTHER;
        checks++; if (fetch_state !== 2'd0) begin failures++; $display("FAIL basic_decode_idle got=%0d exp=0", fetch_state); end
        checks++; if (fetch_done !== 1'b0) begin failures++; $display("FAIL basic_decode_done got=%b exp=0", fetch_done); end
        checks++; if (instruction !== 32'h1C200000) begin failures++; $display("FAIL basic_instr_hold got=%h exp=1c200000", instruction); end
    endtask

    task automatic test_stall();
        simd_state = S_FETCH; current_pc = 8'h05;
        tick();
        simd_state = S_OTHER;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) current_pc = 8'h09;
            checks++; if (mem_read_valid !== 1'b1) begin failures++; $display("FAIL stall_valid_%0d got=%b exp=1", i, mem_read_valid); end
            checks++; if (mem_read_address !== 8'h05) begin failures++; $display("FAIL stall_addr_%0d got=%h exp=05", i, mem_read_address); end
            tick();
        end
        checks++; if (fetch_state !== 2'd1) begin failures++; $display("FAIL stall_state got=%0d exp=1", fetch_state); end
        checks++; if (mem_read_address !== 8'h05) begin failures++; $display("FAIL stall_addr_5th got=%h exp=05", mem_read_address); end
        checks++; if (instruction !== 32'h1C200000) begin failures++; $display("FAIL stall_no_capture got=%h exp=1c200000", instruction); end
        mem_read_ready = 1'b1; mem_read_data = 32'h12345678;
        tick();
        mem_read_ready = 1'b0;
        checks++; if (instruction !== 32'h12345678) begin failures++; $display("FAIL stall_instr got=%h exp=12345678", instruction); end
        checks++; if (fetch_done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", fetch_done); end
        simd_state = S_DECODE;
        tick();
        simd_state = S_OTHER;
    endtask

    task automatic test_enable_freeze();
        simd_state = S_FETCH; current_pc = 8'h03;
        tick();
        simd_state = S_OTHER;
        enable = 1'b0; mem_read_ready = 1'b1; mem_read_data = 32'hA5A5A5A5;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (fetch_state !== 2'd1) begin failures++; $display("FAIL freeze_state_%0d got=%0d exp=1", i, fetch_state); end
            checks++; if (mem_read_valid !== 1'b1) begin failures++; $display("FAIL freeze_valid_%0d got=%b exp=1", i, mem_read_valid); end
            checks++; if (instruction !== 32'h12345678) begin failures++; $display("FAIL freeze_instr_%0d got=%h exp=12345678", i, instruction); end
        end
        enable = 1'b1;
        tick();
        mem_read_ready = 1'b0;
        checks++; if (instruction !== 32'hA5A5A5A5) begin failures++; $display("FAIL freeze_capture got=%h exp=a5a5a5a5", instruction); end
        checks++; if (fetch_state !== 2'd2) begin failures++; $display("FAIL freeze_fetched got=%0d exp=2", fetch_state); end
        simd_state = S_DECODE;
        tick();
        simd_state = S_OTHER;
    endtask

    task automatic test_spurious_ready();
        mem_read_ready = 1'b1; mem_read_data = 32'hDEADBEEF;
        tick();
        mem_read_ready = 1'b0;
        checks++; if (instruction !== 32'hA5A5A5A5) begin failures++; $display("FAIL spur_idle_instr got=%h exp=a5a5a5a5", instruction); end
        checks++; if (fetch_state !== 2'd0) begin failures++; $display("FAIL spur_idle_state got=%0d exp=0", fetch_state); end
        checks++; if (mem_read_valid !== 1'b0) begin failures++; $display("FAIL spur_idle_valid got=%b exp=0", mem_read_valid); end
        simd_state = S_FETCH; current_pc = 8'h07;
        tick();
        simd_state = S_OTHER; mem_read_ready = 1'b1; mem_read_data = 32'h0BADF00D;
        tick();
        mem_read_data = 32'hDEADBEEF;
        tick();
        mem_read_ready = 1'b0;
        checks++; if (instruction !== 32'h0BADF00D) begin failures++; $display("FAIL spur_fetched_instr got=%h exp=0badf00d", instruction); end
        checks++; if (fetch_state !== 2'd2) begin failures++; $display("FAIL spur_fetched_state got=%0d exp=2", fetch_state); end
        simd_state = S_DECODE;
        tick();
        simd_state = S_OTHER;
    endtask

    task automatic test_reset_mid_fetch();
        simd_state = S_FETCH; current_pc = 8'h04;
        tick();
        simd_state = S_OTHER;
        checks++; if (mem_read_address !== 8'h04) begin failures++; $display("FAIL rstmid_addr got=%h exp=04", mem_read_address); end
        rst = 1'b1; mem_read_ready = 1'b1; mem_read_data = 32'hFFFFFFFF;
        tick();
        rst = 1'b0; mem_read_ready = 1'b0;
        checks++; if (instruction !== 32'h0) begin failures++; $display("FAIL rstmid_instr got=%h exp=0", instruction); end
        checks++; if (mem_read_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", mem_read_valid); end
        checks++; if (fetch_state !== 2'd0) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", fetch_state); end
        checks++; if (fetch_done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", fetch_done); end
    endtask

    task automatic test_out_of_range();
        simd_state = S_FETCH; current_pc = 8'h10;
        tick();
        checks++; if (fetch_state !== 2'd3) begin failures++; $display("FAIL oor_state got=%0d exp=3", fetch_state); end
        checks++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL oor_fault got=%b exp=1", fetch_fault); end
        checks++; if (mem_read_valid !== 1'b0) begin failures++; $display("FAIL oor_valid got=%b exp=0", mem_read_valid); end
        current_pc = 8'h02;
        tick();
        checks++; if (fetch_state !== 2'd3) begin failures++; $display("FAIL oor_sticky got=%0d exp=3", fetch_state); end
        checks++; if (mem_read_valid !== 1'b0) begin failures++; $display("FAIL oor_sticky_valid got=%b exp=0", mem_read_valid); end
        simd_state = S_OTHER; rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL oor_clear got=%b exp=0", fetch_fault); end
        checks++; if (fetch_state !== 2'd0) begin failures++; $display("FAIL oor_clear_state got=%0d exp=0", fetch_state); end
        // Highest legal PC must still fetch.
        simd_state = S_FETCH; current_pc = 8'h0F;
        tick();
        simd_state = S_OTHER;
        checks++; if (fetch_state !== 2'd1) begin failures++; $display("FAIL edge_pc_state got=%0d exp=1", fetch_state); end
        checks++; if (mem_read_address !== 8'h0F) begin failures++; $display("FAIL edge_pc_addr got=%h exp=0f", mem_read_address); end
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL edge_pc_fault got=%b exp=0", fetch_fault); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_enable_freeze();
        test_spurious_ready();
        test_reset_mid_fetch();
        test_out_of_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
